// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the multi-cycle RISC-V core: opcodes,
// control-FSM states and the datapath mux select encodings.
package riscv_ctrl_pkg;

  // Major opcodes understood by the control FSM (IR[6:0]).
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_ITYPE  = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_LUI    = 7'b0110111
  } opcode_e;

  // Control FSM states.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_LUI     = 4'd8,
    S_JAL     = 4'd9,
    S_ALU_WB  = 4'd10,
    S_BEQ     = 4'd11,
    S_TRAP    = 4'd12
  } state_e;

  // ALU A input select.
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  // ALU B input select.
  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;

  // ALU operation class.
  localparam logic [1:0] ALU_ADD      = 2'b00;
  localparam logic [1:0] ALU_SUB      = 2'b01;
  localparam logic [1:0] ALU_FUNCT    = 2'b10;

  // Result bus source.
  localparam logic [1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [1:0] RES_RDATA    = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

  // Immediate formats (J = 3'b011 exists in the extender but no state here selects it).
  localparam logic [2:0] IMM_I        = 3'b000;
  localparam logic [2:0] IMM_S        = 3'b001;
  localparam logic [2:0] IMM_B        = 3'b010;
  localparam logic [2:0] IMM_U        = 3'b100;

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM for the multi-cycle RISC-V core. Sequences the shared datapath
// through fetch/decode/execute/memory/writeback, counts retired instructions
// and parks in a sticky trap state on an illegal opcode.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op_code,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic [3:0]       mem_w,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic [1:0]       result_src,
  output logic [3:0]       reg_w,
  output logic             instr_done,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state;
  state_e           state_next;
  logic             retire;
  logic [CNT_W-1:0] count;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (retire) begin
      count <= count + CNT_W'(1);
    end
  end

  // Next-state logic plus the retirement strobe for transitions back to FETCH.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_code)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
          OP_RTYPE:          state_next = S_EXEC_R;
          OP_ITYPE:          state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          OP_LUI:            state_next = S_LUI;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEM_ADR: state_next = (op_code == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end else begin
          state_next = S_MEM_WR;
        end
      end
      S_EXEC_R:  state_next = S_ALU_WB;
      S_EXEC_I:  state_next = S_ALU_WB;
      S_LUI:     state_next = S_ALU_WB;
      S_JAL:     state_next = S_ALU_WB;
      S_ALU_WB, S_BEQ: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP:    state_next = S_TRAP;
      // Unreachable encodings are treated as a fault.
      default:   state_next = S_TRAP;
    endcase
  end

  // Per-state control word; everything is held low while reset is asserted.
  always_comb begin
    mem_req     = 1'b0;
    adr_src     = 1'b0;
    mem_w       = 4'b0000;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    alu_op      = ALU_ADD;
    imm_src     = IMM_I;
    result_src  = RES_ALU_OUT;
    reg_w       = 4'b0000;
    instr_done  = 1'b0;
    trap        = 1'b0;
    instr_count = '0;
    if (!rst_n) begin
      mem_req = 1'b0;
    end else begin
      instr_done  = retire;
      instr_count = count;
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          imm_src   = IMM_B;
        end
        S_MEM_ADR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          imm_src   = (op_code == OP_LOAD) ? IMM_I : IMM_S;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEM_WB: begin
          result_src = RES_RDATA;
          reg_w      = {funct3, 1'b1};
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          mem_w   = {funct3, 1'b1};
        end
        S_EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_op    = ALU_FUNCT;
        end
        S_EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_FUNCT;
        end
        S_LUI: begin
          alu_src_a = SRC_A_ZERO;
          alu_src_b = SRC_B_IMM;
          imm_src   = IMM_U;
        end
        S_JAL: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_FOUR;
          pc_write  = 1'b1;
        end
        S_ALU_WB: begin
          // JAL's IR[14:12] belongs to the immediate, so the link write is a plain word write.
          reg_w = (op_code == OP_JAL) ? 4'b0001 : {funct3, 1'b1};
        end
        S_BEQ: begin
          alu_src_a = SRC_A_RS1;
          alu_op    = ALU_SUB;
          branch    = 1'b1;
          pc_write  = zero;
        end
        S_TRAP:  trap = 1'b1;
        default: trap = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed testbench for multicycle_ctrl_fsm: walks each instruction class
// cycle by cycle and compares the full control word against hand-written vectors.
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op_code;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, adr_src, ir_write, pc_write, branch, instr_done, trap;
  logic [3:0]  mem_w, reg_w;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0]  imm_src;
  logic [31:0] instr_count;
  logic [25:0] obs;

  int n_chk = 0;
  int n_err = 0;

  // Frequently used control words.
  logic [25:0] v_fetch_wait, v_fetch_go, v_decode, v_trap;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src), .mem_w(mem_w),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src), .result_src(result_src),
    .reg_w(reg_w), .instr_done(instr_done), .trap(trap), .instr_count(instr_count)
  );

  assign obs = {mem_req, adr_src, mem_w, ir_write, pc_write, branch, alu_src_a,
                alu_src_b, alu_op, imm_src, result_src, reg_w, instr_done, trap};

  function automatic logic [25:0] pk(input logic mreq, input logic adr, input logic [3:0] mw,
                                     input logic irw, input logic pcw, input logic br,
                                     input logic [1:0] a, input logic [1:0] b, input logic [1:0] aop,
                                     input logic [2:0] imm, input logic [1:0] res,
                                     input logic [3:0] rw, input logic done, input logic trp);
    return {mreq, adr, mw, irw, pcw, br, a, b, aop, imm, res, rw, done, trp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; op_code = 7'b0000011; funct3 = 3'b010; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_chk++;
      if (obs !== 26'd0) begin
        n_err++; $display("FAIL reset_outputs cyc%0d: got %h want %h", i, obs, 26'd0);
      end
      tick();
    end
    rst_n = 1'b0; mem_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (obs !== v_fetch_wait) begin
      n_err++; $display("FAIL reset_fetch: got %h want %h", obs, v_fetch_wait);
    end
    n_chk++;
    if (instr_count !== 32'd0) begin
      n_err++; $display("FAIL reset_count: got %0d want %0d", instr_count, 0);
    end
  endtask

  task automatic test_lw();
    logic [25:0] ev [8];
    logic [0:7]  rdy = 8'b00100010;
    op_code = 7'b0000011; funct3 = 3'b010; zero = 1'b0;
    ev[0] = v_fetch_wait;
    ev[1] = v_fetch_wait;
    ev[2] = v_fetch_go;
    ev[3] = v_decode;
    ev[4] = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00, 4'b0000, 1'b0, 1'b0);
    ev[5] = pk(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0000, 1'b0, 1'b0);
    ev[6] = ev[5];
    ev[7] = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 4'b0101, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i]; #1;
      n_chk++;
      if (obs !== ev[i]) begin
        n_err++; $display("FAIL lw cyc%0d: got %h want %h", i, obs, ev[i]);
      end
      tick();
    end
    n_chk++;
    if (instr_count !== 32'd1) begin
      n_err++; $display("FAIL lw_count: got %0d want %0d", instr_count, 1);
    end
  endtask

  task automatic test_sw();
    logic [25:0] ev [7];
    logic [0:6]  rdy = 7'b1000001;
    op_code = 7'b0100011; funct3 = 3'b000; zero = 1'b0;
    ev[0] = v_fetch_go;
    ev[1] = v_decode;
    ev[2] = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b001, 2'b00, 4'b0000, 1'b0, 1'b0);
    ev[3] = pk(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0000, 1'b0, 1'b0);
    ev[4] = ev[3];
    ev[5] = ev[3];
    ev[6] = pk(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i]; #1;
      n_chk++;
      if (obs !== ev[i]) begin
        n_err++; $display("FAIL sw cyc%0d: got %h want %h", i, obs, ev[i]);
      end
      tick();
    end
    n_chk++;
    if (instr_count !== 32'd2) begin
      n_err++; $display("FAIL sw_count: got %0d want %0d", instr_count, 2);
    end
  endtask

  task automatic test_beq();
    logic [25:0] ev [6];
    op_code = 7'b1100011; funct3 = 3'b000; mem_ready = 1'b1;
    ev[0] = v_fetch_go;
    ev[1] = v_decode;
    ev[2] = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 2'b01, 3'b000, 2'b00, 4'b0000, 1'b1, 1'b0);
    ev[3] = v_fetch_go;
    ev[4] = v_decode;
    ev[5] = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b01, 3'b000, 2'b00, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      zero = (i < 3) ? 1'b1 : 1'b0; #1;
      n_chk++;
      if (obs !== ev[i]) begin
        n_err++; $display("FAIL beq cyc%0d: got %h want %h", i, obs, ev[i]);
      end
      tick();
    end
    n_chk++;
    if (instr_count !== 32'd4) begin
      n_err++; $display("FAIL beq_count: got %0d want %0d", instr_count, 4);
    end
  endtask

  task automatic test_jal();
    logic [25:0] ev [4];
    op_code = 7'b1101111; funct3 = 3'b101; mem_ready = 1'b1; zero = 1'b0;
    ev[0] = v_fetch_go;
    ev[1] = v_decode;
    ev[2] = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00, 4'b0000, 1'b0, 1'b0);
    ev[3] = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++;
      if (obs !== ev[i]) begin
        n_err++; $display("FAIL jal cyc%0d: got %h want %h", i, obs, ev[i]);
      end
      tick();
    end
    n_chk++;
    if (instr_count !== 32'd5) begin
      n_err++; $display("FAIL jal_count: got %0d want %0d", instr_count, 5);
    end
  endtask

  // R-type (funct3 111), I-type (funct3 001) and LUI (IR[14:12] = 011), 4 cycles each.
  task automatic test_alu_ops();
    logic [25:0] ev [12];
    logic [6:0]  ops [3];
    logic [2:0]  f3s [3];
    ops[0] = 7'b0110011; f3s[0] = 3'b111;
    ops[1] = 7'b0010011; f3s[1] = 3'b001;
    ops[2] = 7'b0110111; f3s[2] = 3'b011;
    ev[0]  = v_fetch_go;
    ev[1]  = v_decode;
    ev[2]  = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 4'b0000, 1'b0, 1'b0);
    ev[3]  = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'b1111, 1'b1, 1'b0);
    ev[4]  = v_fetch_go;
    ev[5]  = v_decode;
    ev[6]  = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 3'b000, 2'b00, 4'b0000, 1'b0, 1'b0);
    ev[7]  = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0011, 1'b1, 1'b0);
    ev[8]  = v_fetch_go;
    ev[9]  = v_decode;
    ev[10] = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 3'b100, 2'b00, 4'b0000, 1'b0, 1'b0);
    ev[11] = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0111, 1'b1, 1'b0);
    mem_ready = 1'b1; zero = 1'b0;
    for (int k = 0; k < 3; k++) begin
      op_code = ops[k]; funct3 = f3s[k];
      for (int j = 0; j < 4; j++) begin
        #1;
        n_chk++;
        if (obs !== ev[k*4+j]) begin
          n_err++; $display("FAIL alu_ops op%0d cyc%0d: got %h want %h", k, j, obs, ev[k*4+j]);
        end
        tick();
      end
    end
    n_chk++;
    if (instr_count !== 32'd8) begin
      n_err++; $display("FAIL alu_ops_count: got %0d want %0d", instr_count, 8);
    end
  endtask

  task automatic test_reset_mid_wr();
    logic [25:0] ev [4];
    logic [0:3]  rdy = 4'b1000;
    op_code = 7'b0100011; funct3 = 3'b010; zero = 1'b0;
    ev[0] = v_fetch_go;
    ev[1] = v_decode;
    ev[2] = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b001, 2'b00, 4'b0000, 1'b0, 1'b0);
    ev[3] = pk(1'b1, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      mem_ready = rdy[i]; #1;
      n_chk++;
      if (obs !== ev[i]) begin
        n_err++; $display("FAIL rst_wr cyc%0d: got %h want %h", i, obs, ev[i]);
      end
      tick();
    end
    // Still in MEM_WR waiting; pull reset mid-access.
    rst_n = 1'b0; mem_ready = 1'b0; #1;
    n_chk++;
    if (obs !== 26'd0) begin
      n_err++; $display("FAIL rst_wr_outputs: got %h want %h", obs, 26'd0);
    end
    tick();
    rst_n = 1'b1; #1;
    n_chk++;
    if (obs !== v_fetch_wait) begin
      n_err++; $display("FAIL rst_wr_fetch: got %h want %h", obs, v_fetch_wait);
    end
    n_chk++;
    if (instr_count !== 32'd0) begin
      n_err++; $display("FAIL rst_wr_count: got %0d want %0d", instr_count, 0);
    end
    tick();
  endtask

  task automatic test_trap();
    op_code = 7'b1111111; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
    #1;
    n_chk++;
    if (obs !== v_fetch_go) begin
      n_err++; $display("FAIL trap_fetch: got %h want %h", obs, v_fetch_go);
    end
    tick(); #1;
    n_chk++;
    if (obs !== v_decode) begin
      n_err++; $display("FAIL trap_decode: got %h want %h", obs, v_decode);
    end
    tick();
    for (int i = 0; i < 12; i++) begin
      mem_ready = i[0]; #1;
      n_chk++;
      if (obs !== v_trap) begin
        n_err++; $display("FAIL trap_hold cyc%0d: got %h want %h", i, obs, v_trap);
      end
      tick();
    end
    rst_n = 1'b0; mem_ready = 1'b0; #1;
    n_chk++;
    if (obs !== 26'd0) begin
      n_err++; $display("FAIL trap_rst_outputs: got %h want %h", obs, 26'd0);
    end
    tick();
    rst_n = 1'b1; #1;
    n_chk++;
    if (obs !== v_fetch_wait) begin
      n_err++; $display("FAIL trap_rst_fetch: got %h want %h", obs, v_fetch_wait);
    end
  endtask

  initial begin
    v_fetch_wait = pk(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b10, 4'b0000, 1'b0, 1'b0);
    v_fetch_go   = pk(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b10, 4'b0000, 1'b0, 1'b0);
    v_decode     = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 3'b010, 2'b00, 4'b0000, 1'b0, 1'b0);
    v_trap       = pk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0000, 1'b0, 1'b1);
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_jal();
    test_alu_ops();
    test_reset_mid_wr();
    test_trap();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
